lcd_frame_guard: RTL and testbench
==================================

Name: lcd_frame_guard

Overview:
- Sits between the clocked-video output (interface timing converter) and the MTL2 LCD / on-board VGA pins, in the video clock domain.
- Retimes active-high HS/VS/DE/RGB from the timing converter and drives active-low panel syncs.
- Checks every line and frame against the expected active geometry.
- Blanks RGB and DE until the stream has been clean for LOCK_FRAMES consecutive frames.
- Counts malformed frames for software/LED status.

Parameters:
H_ACTIVE, 800, expected DE-high pixels per line (range 1..4095)
V_ACTIVE, 480, expected DE-active lines per frame (range 1..4095)
LOCK_FRAMES, 2, consecutive good frames required to lock (range 1..15)

Ports:
clk  in  1  video pixel clock (33.3 MHz)
rst  in  1  reset, asynchronous, active-high
vid_hs  in  1  horizontal sync from timing converter, active-high
vid_vs  in  1  vertical sync from timing converter, active-high
vid_de  in  1  data valid from timing converter
vid_data  in  24  {R,G,B} pixel
err_clr  in  1  synchronous clear of err_count (single-cycle pulse)
lcd_hs_n  out  1  panel HSD, active-low
lcd_vs_n  out  1  panel VSD, active-low
lcd_de  out  1  gated data enable
lcd_data  out  24  gated {R,G,B}
locked  out  1  high while in LOCKED
err_count  out  8  saturating count of bad frames

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values (asserted asynchronously, held while rst=1):
  - lcd_hs_n=1, lcd_vs_n=1, lcd_de=0, lcd_data=0, locked=0, err_count=0.
  - All internal counters 0; state=SEARCH.
  - Reset mid-frame discards the partial frame.
- Pipeline: stage 1 registers all vid_* inputs; stage 2 is the output register. Fixed latency of 2 clocks from input to output for hs/vs/de/data. Syncs are inverted at stage 2 and are never gated.
- Edge detection uses stage-1 values against their previous values:
  - VS rise = frame start.
  - DE rise = line start.
  - DE fall = line end.
- pix_cnt (12 bit):
  - Cleared on DE rise, then incremented on each DE-high cycle. The DE-rise cycle loads 1.
  - Saturates at 4095.
- Line end: if pix_cnt != H_ACTIVE, set frame_bad.
- line_cnt (12 bit): incremented on DE rise, saturates at 4095.
- Frame end, at VS rise:
  - The frame is good iff frame_bad=0 and line_cnt==V_ACTIVE.
  - Then clear line_cnt and frame_bad.
- Same-cycle events:
  - A line end coinciding with VS rise is evaluated first and included in that frame's verdict.
  - A DE rise coinciding with VS rise counts toward the new frame.
- FSM:
  - SEARCH: wait for the first VS rise; on it enter CHECK with good_cnt=0. The partial frame before it is not judged.
  - CHECK:
    - At each VS rise, a good frame increments good_cnt; a bad frame clears good_cnt and increments err_count.
    - When good_cnt reaches LOCK_FRAMES, enter LOCKED on that same VS rise.
    - A bad line does not change state until the frame verdict.
  - LOCKED:
    - A bad line (pix_cnt mismatch at DE fall) immediately goes to CHECK, good_cnt=0. This frame is bad and increments err_count at its VS rise.
    - A bad frame verdict (line count) at VS rise also goes to CHECK and increments err_count.
- Gating:
  - Stage 2 drives lcd_de=stage1 de and lcd_data=stage1 data only when the state is LOCKED in the cycle stage 2 loads. Otherwise it drives lcd_de=0, lcd_data=0.
  - Lock takes effect from the VS rise of the new frame.
  - Unlock takes effect on the clock after the mismatching DE fall. Remaining pixels of that frame are blanked.
- locked is a registered copy of (state==LOCKED), aligned with the gating.
- err_count:
  - Saturates at 255.
  - err_clr clears it to 0.
  - If err_clr coincides with an increment, the result is 0.
- Input data is never modified; only passed through or zeroed.

Test Plan:
- Override H_ACTIVE=8, V_ACTIVE=4, LOCK_FRAMES=2.
- Reset mid-stream: drive stream, assert rst asynchronously between clock edges -> outputs immediately hs_n=1, vs_n=1, de=0, data=0, locked=0, err_count=0.
- Clean lock: 4 clean frames (8 px x 4 lines) after reset -> lcd_de=0 through the partial frame plus frames 1-2. locked rises at the 3rd VS rise. Frame 3 pixels appear on lcd_data exactly 2 clocks after input, e.g. 0xA5C3E1 in -> 0xA5C3E1 out. err_count=0.
- Short line: while locked, send line 2 with 7 px -> locked=0 on the clock after that DE fall. Remaining lcd_de=0. err_count=1 at next VS rise. Relock after 2 more clean frames.
- Frame length: while locked, send a frame with 5 lines of 8 px -> locked stays 1 until VS rise, then locked=0 and err_count increments by 1.
- Saturation/clear: 300 bad frames -> err_count=255. err_clr pulse coincident with a bad-frame VS rise -> err_count=0.
- Sync polarity/latency: vid_hs pulse of 3 clocks -> lcd_hs_n low for 3 clocks, 2 clocks later, whether locked or not.

Source files
------------

// File: rtl/lcd_frame_guard.sv
// Video retimer and geometry guard between the timing converter and the LCD panel.
// Pixels are blanked until LOCK_FRAMES consecutive clean frames have been seen.
//
// state  | meaning
// SEARCH | waiting for the first frame start after reset
// CHECK  | judging frames, counting consecutive good ones
// LOCKED | stream trusted, pixels forwarded to the panel
module lcd_frame_guard #(
   parameter int H_ACTIVE    = 800,
   parameter int V_ACTIVE    = 480,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vid_hs,
   input  logic        vid_vs,
   input  logic        vid_de,
   input  logic [23:0] vid_data,
   input  logic        err_clr,
   output logic        lcd_hs_n,
   output logic        lcd_vs_n,
   output logic        lcd_de,
   output logic [23:0] lcd_data,
   output logic        locked,
   output logic [7:0]  err_count
);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [11:0] H_EXP  = 12'(H_ACTIVE);
   localparam logic [11:0] V_EXP  = 12'(V_ACTIVE);
   localparam logic [3:0]  G_LOCK = 4'(LOCK_FRAMES);
   localparam logic [11:0] CNT_MAX = 12'hFFF;

   logic        r_hs1, r_vs1, r_de1;
   logic [23:0] r_data1;
   logic        r_vs1_d, r_de1_d;
   logic [11:0] r_pix_cnt;
   logic [11:0] r_line_cnt;
   logic        r_frame_bad;
   logic [3:0]  r_good_cnt;
   logic [7:0]  r_err_cnt;
   state_t      r_state;
   logic        r_hs_n, r_vs_n, r_de2, r_locked;
   logic [23:0] r_data2;

   logic        w_vs_rise, w_de_rise, w_de_fall;
   logic        w_line_bad, w_frame_good;
   logic        w_err_inc, w_pass;
   logic [3:0]  w_good_inc;
   logic [3:0]  w_good_nxt;
   state_t      w_state_nxt;

   assign w_vs_rise    = r_vs1 & ~r_vs1_d;
   assign w_de_rise    = r_de1 & ~r_de1_d;
   assign w_de_fall    = ~r_de1 & r_de1_d;
   assign w_line_bad   = w_de_fall & (r_pix_cnt != H_EXP);
   // A line ending in the same cycle as the frame start still belongs to the old frame.
   assign w_frame_good = ~(r_frame_bad | w_line_bad) & (r_line_cnt == V_EXP);
   assign w_good_inc   = r_good_cnt + 4'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hs1   <= 1'b0;
         r_vs1   <= 1'b0;
         r_de1   <= 1'b0;
         r_data1 <= '0;
         r_vs1_d <= 1'b0;
         r_de1_d <= 1'b0;
      end else begin
         r_hs1   <= vid_hs;
         r_vs1   <= vid_vs;
         r_de1   <= vid_de;
         r_data1 <= vid_data;
         r_vs1_d <= r_vs1;
         r_de1_d <= r_de1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pix_cnt   <= '0;
         r_line_cnt  <= '0;
         r_frame_bad <= 1'b0;
      end else begin
         if (w_de_rise) begin
            r_pix_cnt <= 12'd1;
         end else if (r_de1 && (r_pix_cnt != CNT_MAX)) begin
            r_pix_cnt <= r_pix_cnt + 12'd1;
         end

         if (w_vs_rise) begin
            r_line_cnt <= w_de_rise ? 12'd1 : 12'd0;
         end else if (w_de_rise && (r_line_cnt != CNT_MAX)) begin
            r_line_cnt <= r_line_cnt + 12'd1;
         end

         if (w_vs_rise) begin
            r_frame_bad <= 1'b0;
         end else if (w_line_bad) begin
            r_frame_bad <= 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_good_nxt  = r_good_cnt;
      w_err_inc   = 1'b0;
      case (r_state)
         SEARCH: begin
            if (w_vs_rise) begin
               w_state_nxt = CHECK;
               w_good_nxt  = '0;
            end
         end
         CHECK: begin
            if (w_vs_rise) begin
               if (w_frame_good) begin
                  w_good_nxt = w_good_inc;
                  if (w_good_inc == G_LOCK) begin
                     w_state_nxt = LOCKED;
                  end
               end else begin
                  w_good_nxt = '0;
                  w_err_inc  = 1'b1;
               end
            end
         end
         LOCKED: begin
            if (w_vs_rise && !w_frame_good) begin
               w_state_nxt = CHECK;
               w_good_nxt  = '0;
               w_err_inc   = 1'b1;
            end else if (w_line_bad) begin
               // Drop out at once; the frame_bad flag charges the error at the next frame start.
               w_state_nxt = CHECK;
               w_good_nxt  = '0;
            end
         end
         default: begin
            w_state_nxt = SEARCH;
            w_good_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= SEARCH;
         r_good_cnt <= '0;
         r_err_cnt  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_good_cnt <= w_good_nxt;
         if (err_clr) begin
            r_err_cnt <= '0;
         end else if (w_err_inc && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
      end
   end

   // Gate with the state being entered so lock/unlock line up with the stage-2 load.
   assign w_pass = (w_state_nxt == LOCKED);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hs_n   <= 1'b1;
         r_vs_n   <= 1'b1;
         r_de2    <= 1'b0;
         r_data2  <= '0;
         r_locked <= 1'b0;
      end else begin
         r_hs_n   <= ~r_hs1;
         r_vs_n   <= ~r_vs1;
         r_de2    <= w_pass & r_de1;
         r_data2  <= w_pass ? r_data1 : 24'd0;
         r_locked <= w_pass;
      end
   end

   assign lcd_hs_n  = r_hs_n;
   assign lcd_vs_n  = r_vs_n;
   assign lcd_de    = r_de2;
   assign lcd_data  = r_data2;
   assign locked    = r_locked;
   assign err_count = r_err_cnt;

endmodule

// File: tb/tb_lcd_frame_guard.sv
// Randomised frame stream against a frame-level reference model; a scoreboard
// queue holds expected outputs and a negedge monitor compares them.
module tb_lcd_frame_guard;

   localparam int H = 8;
   localparam int V = 4;
   localparam int L = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vid_hs = 1'b0, vid_vs = 1'b0, vid_de = 1'b0, err_clr = 1'b0;
   logic [23:0] vid_data = '0;
   logic        lcd_hs_n, lcd_vs_n, lcd_de, locked;
   logic [23:0] lcd_data;
   logic [7:0]  err_count;

   always #5 clk = ~clk;

   lcd_frame_guard #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(L)) dut (
      .clk(clk), .rst(rst),
      .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de), .vid_data(vid_data),
      .err_clr(err_clr),
      .lcd_hs_n(lcd_hs_n), .lcd_vs_n(lcd_vs_n), .lcd_de(lcd_de), .lcd_data(lcd_data),
      .locked(locked), .err_count(err_count)
   );

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        de;
      logic [23:0] d;
   } smp_t;

   // Reference model: trust level of the incoming stream.
   localparam int M_WAIT_VS = 0;
   localparam int M_QUALIFY = 1;
   localparam int M_TRUST   = 2;

   logic [35:0] sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   mon_en  = 1'b0;
   bit   seen_a5 = 1'b0;

   int   m_mode, m_good, m_run, m_lines, m_err;
   bit   m_fbad;
   smp_t m_prev, m_cur;

   task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_WAIT_VS; m_good = 0; m_run = 0; m_lines = 0; m_err = 0; m_fbad = 0;
      m_prev = '0; m_cur = '0;
   endtask

   // Judge sample c (preceded by p); clr is the err_clr seen while c is being judged.
   task automatic model_step(input smp_t p, input smp_t c, input bit clr);
      bit vs_rise, de_rise, de_fall, line_bad, good, inc, pass;
      vs_rise  = c.vs && !p.vs;
      de_rise  = c.de && !p.de;
      de_fall  = !c.de && p.de;
      line_bad = de_fall && (m_run != H);
      if (line_bad) m_fbad = 1;
      if (c.de) m_run = de_rise ? 1 : m_run + 1;
      inc = 0;
      if (vs_rise) begin
         good = !m_fbad && (m_lines == V);
         if (m_mode == M_WAIT_VS) begin
            m_mode = M_QUALIFY; m_good = 0;
         end else if (!good) begin
            m_mode = M_QUALIFY; m_good = 0; inc = 1;
         end else if (m_mode == M_QUALIFY) begin
            m_good++;
            if (m_good == L) m_mode = M_TRUST;
         end
         m_lines = 0;
         m_fbad  = 0;
      end else if (line_bad && m_mode == M_TRUST) begin
         m_mode = M_QUALIFY; m_good = 0;
      end
      if (de_rise) m_lines++;
      if (clr) m_err = 0;
      else if (inc && m_err < 255) m_err++;
      pass = (m_mode == M_TRUST);
      sb_q.push_back({~c.hs, ~c.vs, pass & c.de, pass ? c.d : 24'd0, pass, 8'(m_err)});
   endtask

   task automatic cyc(input logic hs, input logic vs, input logic de,
                      input logic [23:0] d, input logic clr);
      smp_t s;
      @(posedge clk);
      #1;
      vid_hs = hs; vid_vs = vs; vid_de = de; vid_data = d; err_clr = clr;
      model_step(m_prev, m_cur, clr);
      s = {hs, vs, de, d};
      m_prev = m_cur;
      m_cur  = s;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 0, 0, 24'd0, 0);
   endtask

   task automatic send_line(input int len, input bit use_first, input logic [23:0] first_px);
      repeat ($urandom_range(3, 1)) cyc(1, 0, 0, 24'd0, 0);
      repeat ($urandom_range(2, 1)) cyc(0, 0, 0, 24'd0, 0);
      for (int p = 0; p < len; p++)
         cyc(0, 0, 1, (p == 0 && use_first) ? first_px : 24'($urandom), 0);
      repeat ($urandom_range(2, 1)) cyc(0, 0, 0, 24'd0, 0);
   endtask

   task automatic send_frame(input int nlines, input int bad_idx, input int bad_len,
                             input bit clr_vs, input bit use_first, input logic [23:0] first_px);
      cyc(1, 1, 0, 24'd0, 0);
      cyc(1, 1, 0, 24'd0, clr_vs);
      cyc(0, 1, 0, 24'd0, 0);
      repeat ($urandom_range(3, 2)) cyc(0, 0, 0, 24'd0, 0);
      for (int l = 0; l < nlines; l++)
         send_line((l == bad_idx) ? bad_len : H, use_first && l == 0, first_px);
   endtask

   task automatic do_reset();
      mon_en = 0;
      @(posedge clk);
      #4;
      rst = 1'b1;
      #1;
      chk("rst_hs_n",  36'(lcd_hs_n),  36'd1);
      chk("rst_vs_n",  36'(lcd_vs_n),  36'd1);
      chk("rst_de",    36'(lcd_de),    36'd0);
      chk("rst_data",  36'(lcd_data),  36'd0);
      chk("rst_locked",36'(locked),    36'd0);
      chk("rst_err",   36'(err_count), 36'd0);
      vid_hs = 0; vid_vs = 0; vid_de = 0; vid_data = '0; err_clr = 0;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      sb_q.delete();
      model_reset();
      mon_en = 1;
   endtask

   always @(negedge clk) begin
      logic [35:0] e;
      if (mon_en && sb_q.size() >= 2) begin
         e = sb_q.pop_front();
         chk("stream", {lcd_hs_n, lcd_vs_n, lcd_de, lcd_data, locked, err_count}, e);
         if (lcd_de && lcd_data == 24'hA5C3E1) seen_a5 = 1;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nl, bi, bl;
      model_reset();
      do_reset();

      // partial frame before the first frame start is never judged
      send_line(H, 0, 24'd0);
      send_line(5, 0, 24'd0);
      for (int f = 0; f < 4; f++) send_frame(V, -1, H, 0, f == 2, 24'hA5C3E1);
      idle(4);
      chk("lock_locked", 36'(locked), 36'd1);
      chk("lock_err", 36'(err_count), 36'd0);
      chk("lock_a5_seen", 36'(seen_a5), 36'd1);

      // short line while locked
      send_frame(V, 1, H - 1, 0, 0, 24'd0);
      idle(2);
      chk("short_unlocked", 36'(locked), 36'd0);
      chk("short_err_pending", 36'(err_count), 36'd0);
      send_frame(V, -1, H, 0, 0, 24'd0);
      chk("short_err", 36'(err_count), 36'd1);
      send_frame(V, -1, H, 0, 0, 24'd0);
      send_frame(V, -1, H, 0, 0, 24'd0);
      chk("short_relock", 36'(locked), 36'd1);

      // frame with one line too many
      send_frame(V + 1, -1, H, 0, 0, 24'd0);
      idle(2);
      chk("long_still_locked", 36'(locked), 36'd1);
      send_frame(V, -1, H, 0, 0, 24'd0);
      chk("long_unlocked", 36'(locked), 36'd0);
      chk("long_err", 36'(err_count), 36'd2);
      send_frame(V, -1, H, 0, 0, 24'd0);
      send_frame(V, -1, H, 0, 0, 24'd0);
      chk("long_relock", 36'(locked), 36'd1);

      // asynchronous reset in the middle of an active line
      cyc(1, 1, 0, 24'd0, 0);
      cyc(0, 0, 0, 24'd0, 0);
      send_line(H, 0, 24'd0);
      for (int p = 0; p < 4; p++) cyc(0, 0, 1, 24'($urandom), 0);
      do_reset();

      // randomised stream with occasional geometry faults
      for (int f = 0; f < 25; f++) begin
         nl = ($urandom_range(4, 0) == 0) ? $urandom_range(V + 1, V - 1) : V;
         bi = ($urandom_range(3, 0) == 0) ? $urandom_range(nl - 1, 0) : -1;
         bl = ($urandom_range(1, 0) == 0) ? H - 1 : H + 1;
         send_frame(nl, bi, bl, ($urandom_range(9, 0) == 0), 0, 24'd0);
      end

      // saturate, then clear on a coincident increment
      for (int f = 0; f < 300; f++) send_frame(V - 1, -1, H, 0, 0, 24'd0);
      idle(3);
      chk("sat_err", 36'(err_count), 36'd255);
      send_frame(V - 1, -1, H, 1, 0, 24'd0);
      idle(3);
      chk("clr_err", 36'(err_count), 36'd0);

      // standalone hsync pulse
      idle(2);
      repeat (3) cyc(1, 0, 0, 24'd0, 0);
      idle(6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
